// File: rtl/char_pkg.sv
// char_pkg: screen defaults, colour width, flusher state encoding and glyph codes shared with the decoder mux.
package char_pkg;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int COLOUR_W = 6;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} flusher_state_t;
  localparam logic [5:0] CHAR_A     = 6'd0;
  localparam logic [5:0] CHAR_U     = 6'd20;
  localparam logic [5:0] CHAR_SPACE = 6'd36;
endpackage

// File: rtl/cell_scan_counter.sv
// cell_scan_counter: row-major col/row sweep over one CELL_W x CELL_H character cell.
module cell_scan_counter #(
  parameter int CELL_W = 10,
  parameter int CELL_H = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       advance,
  output logic [3:0] col,
  output logic [3:0] row,
  output logic       last
);
  logic [3:0] col_q, col_d, row_q, row_d;
  logic       col_end;
  always_comb begin
    col_end = col_q == 4'(CELL_W - 1);
    last    = col_end && row_q == 4'(CELL_H - 1);
    col_d   = clear ? 4'd0 : advance ? (col_end ? 4'd0 : col_q + 4'd1) : col_q;
    row_d   = clear ? 4'd0 : (advance && col_end) ? (last ? 4'd0 : row_q + 4'd1) : row_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  assign col = col_q;
  assign row = row_q;
endmodule

// File: rtl/char_flusher.sv
// char_flusher: scans one character cell through the glyph decoder and emits registered plot strobes.
// Define CHAR_FLUSHER_BG_FILL_EN to plot unlit in-screen pixels with bg_colour.
module char_flusher
  import char_pkg::*;
#(
  parameter int CELL_W   = 10,
  parameter int CELL_H   = 10,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [5:0]          char_code,
  input  logic [7:0]          origin_x,
  input  logic [7:0]          origin_y,
  input  logic [COLOUR_W-1:0] bg_colour,
  output logic [5:0]          glyph_sel,
  output logic [7:0]          char_x,
  output logic [7:0]          char_y,
  output logic [7:0]          flush_x,
  output logic [7:0]          flush_y,
  input  logic [COLOUR_W-1:0] glyph_colour,
  input  logic                glyph_enable,
  output logic                plot,
  output logic [7:0]          plot_x,
  output logic [7:0]          plot_y,
  output logic [COLOUR_W-1:0] plot_colour,
  output logic                busy,
  output logic                done
);
`ifdef CHAR_FLUSHER_BG_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif
  flusher_state_t      state_q, state_d;
  logic [5:0]          glyph_q, glyph_d;
  logic [7:0]          cx_q, cx_d, cy_q, cy_d;
  logic                plot_q, plot_d;
  logic [7:0]          px_q, px_d, py_q, py_d;
  logic [COLOUR_W-1:0] pc_q, pc_d;
  logic                clear, advance, last, on_screen;
  logic [3:0]          col, row;
  logic [8:0]          sx, sy;
  cell_scan_counter #(.CELL_W(CELL_W), .CELL_H(CELL_H)) u_cnt (
    .clk(clk), .reset(reset), .clear(clear), .advance(advance),
    .col(col), .row(row), .last(last)
  );
  always_comb begin
    clear     = state_q == IDLE && start;
    advance   = state_q == SCAN;
    glyph_d   = clear ? char_code : glyph_q;
    cx_d      = clear ? origin_x : cx_q;
    cy_d      = clear ? origin_y : cy_q;
    state_d   = clear ? SCAN
              : state_q == SCAN  ? (last ? DRAIN : SCAN)
              : state_q == DRAIN ? DONE
              : IDLE;
    sx        = {1'b0, cx_q} + {5'd0, col};
    sy        = {1'b0, cy_q} + {5'd0, row};
    // the carry bit is a wrapped coordinate, never a visible one
    on_screen = !sx[8] && !sy[8] && sx < 9'(SCREEN_W) && sy < 9'(SCREEN_H);
    plot_d    = advance && on_screen && (glyph_enable || FILL);
    px_d      = sx[7:0];
    py_d      = sy[7:0];
    pc_d      = (glyph_enable || !FILL) ? glyph_colour : bg_colour;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      glyph_q <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      plot_q  <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      glyph_q <= glyph_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      plot_q  <= plot_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pc_q    <= pc_d;
    end
  assign glyph_sel   = glyph_q;
  assign char_x      = cx_q;
  assign char_y      = cy_q;
  assign flush_x     = sx[7:0];
  assign flush_y     = sy[7:0];
  assign plot        = plot_q;
  assign plot_x      = px_q;
  assign plot_y      = py_q;
  assign plot_colour = pc_q;
  assign busy        = state_q != IDLE;
  assign done        = state_q == DONE;
endmodule

// File: tb/tb_char_flusher.sv
// tb_char_flusher: randomized cell draws checked against an expected-plot list built from cell geometry and a glyph model.
module tb_char_flusher;
`ifdef CHAR_FLUSHER_BG_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [5:0] char_code = '0, bg_colour = '0, glyph_sel, plot_colour, glyph_colour;
  logic [7:0] origin_x = '0, origin_y = '0, char_x, char_y, flush_x, flush_y, plot_x, plot_y;
  logic [7:0] lx, ly;
  logic       glyph_enable, plot, busy, done;
  int         vectors = 0, errors = 0;
  always #5 clk = ~clk;
  char_flusher dut (
    .clk(clk), .reset(reset), .start(start), .char_code(char_code),
    .origin_x(origin_x), .origin_y(origin_y), .bg_colour(bg_colour),
    .glyph_sel(glyph_sel), .char_x(char_x), .char_y(char_y),
    .flush_x(flush_x), .flush_y(flush_y), .glyph_colour(glyph_colour),
    .glyph_enable(glyph_enable), .plot(plot), .plot_x(plot_x), .plot_y(plot_y),
    .plot_colour(plot_colour), .busy(busy), .done(done)
  );
  function automatic bit lit(int x, int y, int g);
    return ((x * 3 + y * 5 + g) % 7) < 3;
  endfunction
  function automatic logic [5:0] gcol(int x, int y, int g);
    return 6'((x * 4 + y + g * 9) & 63);
  endfunction
  // glyph decoder stand-in: pixel relative to the latched origin
  assign lx = flush_x - char_x;
  assign ly = flush_y - char_y;
  assign glyph_enable = lit(int'(lx), int'(ly), int'(glyph_sel));
  assign glyph_colour = gcol(int'(lx), int'(ly), int'(glyph_sel));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic draw(input logic [7:0] ox, input logic [7:0] oy, input logic [5:0] g, input logic [5:0] bg);
    logic [21:0] q[$];
    logic [21:0] e;
    int x, y, c;
    for (int r = 0; r < 10; r++)
      for (int k = 0; k < 10; k++) begin
        x = int'(ox) + k;
        y = int'(oy) + r;
        if (x < 160 && y < 120 && (lit(k, r, int'(g)) || FILL))
          q.push_back({8'(x), 8'(y), lit(k, r, int'(g)) ? gcol(k, r, int'(g)) : bg});
      end
    @(negedge clk);
    origin_x = ox; origin_y = oy; char_code = g; bg_colour = bg; start = 1'b1;
    for (int k = 0; k <= 102; k++) begin
      if (k > 0) begin
        @(negedge clk);
        start = k < 102 && (k == 5 || k == 101 || $urandom_range(0, 15) == 0);
        origin_x = 8'($urandom); origin_y = 8'($urandom); char_code = 6'($urandom);
      end
      @(posedge clk);
      #1;
      c = k + 1;
      check("busy", 32'(busy), 32'(c <= 102));
      check("done", 32'(done), 32'(c == 102));
      if (c == 1) check("latch", {10'd0, glyph_sel, char_x, char_y}, {10'd0, g, ox, oy});
      if (plot) begin
        if (q.size() == 0) check("plot_extra", 32'(plot), 32'd0);
        else begin
          e = q.pop_front();
          check("plot", {10'd0, plot_x, plot_y, plot_colour}, {10'd0, e});
        end
      end
    end
    check("plot_idle", 32'(plot), 32'd0);
    check("plots_missing", 32'(q.size()), 32'd0);
  endtask
  task automatic check_cleared(input string tag);
    check(tag, {2'd0, busy, done, plot, glyph_sel, char_x, char_y, 3'd0},
           32'd0);
    check({tag, "_pix"}, {plot_x, plot_y, flush_x, flush_y}, 32'd0);
    check({tag, "_col"}, 32'(plot_colour), 32'd0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    reset = 1'b0;
    draw(8'd10, 8'd20, 6'd20, 6'h01);
    draw(8'd155, 8'd115, 6'd3, 6'h2A);
    draw(8'd250, 8'd30, 6'd7, 6'h15);
    draw(8'd30, 8'd250, 6'd11, 6'h3F);
    draw(8'd0, 8'd0, 6'd0, 6'h00);
    draw(8'd151, 8'd111, 6'd63, 6'h22);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      draw(8'($urandom), 8'($urandom_range(0, 130)), 6'($urandom), 6'($urandom));
    end
    @(negedge clk);
    origin_x = 8'd40; origin_y = 8'd50; char_code = 6'd9; start = 1'b1;
    repeat (40) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check_cleared("mid_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 110; k++) begin
      @(posedge clk);
      #1;
      check("post_reset", {29'd0, busy, done, plot}, 32'd0);
    end
    draw(8'd40, 8'd50, 6'd9, 6'h0C);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
